// File: rtl/screen_scanner.sv
// Framebuffer scan-out: prefetches one word ahead over a req/ack read port,
// serializes 16 pixels per word and generates raster sync/active timing.
module screen_scanner #(
  parameter int H_ACTIVE = 512,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 64,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 256,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int BASE_ADR = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic        fb_req,
  output logic [14:0] fb_adr,
  input  logic        fb_ack,
  input  logic [15:0] fb_data,
  output logic        pixel,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int WORDS   = (H_ACTIVE / 16) * V_ACTIVE;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int FW      = $clog2(WORDS + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [FW-1:0] WORD_CNT = FW'(WORDS);
  localparam logic [14:0]   ADR_BASE = 15'(BASE_ADR);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic [15:0]     shift_word;
  logic [15:0]     next_word;
  logic            next_full;
  logic [FW-1:0]   fetch_idx;
  logic            discard;

  logic            visible;
  logic            word_start;
  logic            load;
  logic            flush;
  logic            accept;
  logic            keep;
  logic [15:0]     cur_word;

  assign visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign word_start = visible && (h_cnt[3:0] == 4'd0);
  assign load       = pix_en && word_start;
  assign flush      = pix_en && (h_cnt == '0) && (v_cnt == V_VIS);
  assign accept     = (state_q == REQ) && fb_ack;
  // A flush on the same edge as an ack wins: that word belongs to the old frame.
  assign keep       = accept && !discard && !flush;
  assign fb_req     = (state_q == REQ);

  // The first pixel of a word comes straight from the prefetch slot so the
  // registered pixel output lines up with the word boundary.
  assign cur_word = word_start ? (next_full ? next_word : 16'h0000) : shift_word;

  // Raster counters.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Registered video outputs; they hold between pixel enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel  <= 1'b0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      active <= 1'b0;
    end else if (pix_en) begin
      pixel  <= visible && cur_word[h_cnt[3:0]];
      hsync  <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vsync  <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      active <= visible;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else begin
      underrun <= load && !next_full;
    end
  end

  // Shift/prefetch buffering and frame bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_word <= '0;
      next_word  <= '0;
      next_full  <= 1'b0;
      fetch_idx  <= '0;
      discard    <= 1'b0;
    end else begin
      if (load) begin
        shift_word <= cur_word;
      end

      if (keep) begin
        next_word <= fb_data;
      end

      if (flush) begin
        next_full <= 1'b0;
        fetch_idx <= '0;
      end else if (keep) begin
        next_full <= 1'b1;
        fetch_idx <= fetch_idx + FW'(1);
      end else if (load) begin
        next_full <= 1'b0;
      end

      // An in-flight request that straddles the flush completes but is dropped.
      if (accept) begin
        discard <= 1'b0;
      end else if (flush && (state_q == REQ)) begin
        discard <= 1'b1;
      end
    end
  end

  // Fetch FSM.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!next_full && (fetch_idx < WORD_CNT) && !flush) state_d = REQ;
      REQ:  if (fb_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fb_adr  <= ADR_BASE;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && (state_d == REQ)) begin
        fb_adr <= ADR_BASE + 15'(fetch_idx);
      end
    end
  end

endmodule

// File: tb/tb_screen_scanner.sv
// Scoreboard bench for screen_scanner on a reduced 32x4-pixel raster (8 words):
// expected pixels and fetch addresses are queued up front and popped as the DUT emits them.
module tb_screen_scanner;

  localparam int H_ACTIVE = 32;
  localparam int H_FRONT  = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BACK   = 4;
  localparam int V_ACTIVE = 4;
  localparam int V_FRONT  = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 2;
  localparam int BASE     = 16384;
  localparam int H_TOTAL  = 48;
  localparam int V_TOTAL  = 10;
  localparam int FRAME    = 480;
  localparam int WORDS    = 8;

  logic        clk;
  logic        rst_n;
  logic        pix_en;
  logic        fb_req;
  logic [14:0] fb_adr;
  logic        fb_ack;
  logic [15:0] fb_data;
  logic        pixel;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        underrun;

  screen_scanner #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .BASE_ADR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .fb_req(fb_req), .fb_adr(fb_adr), .fb_ack(fb_ack), .fb_data(fb_data),
    .pixel(pixel), .hsync(hsync), .vsync(vsync), .active(active), .underrun(underrun)
  );

  typedef struct packed {
    logic pix;
    logic und;
  } pix_exp_t;

  pix_exp_t    pix_q[$];
  int          adr_q[$];
  logic [15:0] mem [WORDS];
  int          checks = 0;
  int          errors = 0;
  int          ticks = 0;
  int          last_ticks = 0;
  bit          late_mode = 0;
  bit          hold7 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Slot map: nibble s = word shown in word slot s, 4'hF = underrun slot.
  task automatic push_frame(input logic [31:0] m);
    for (int s = 0; s < 8; s++) begin
      logic [3:0] w;
      w = m[4*s +: 4];
      for (int b = 0; b < 16; b++) begin
        pix_exp_t e;
        e.pix = (w == 4'hF) ? 1'b0 : mem[int'(w)][b];
        e.und = (w == 4'hF) && (b == 0);
        pix_q.push_back(e);
      end
    end
  endtask

  task automatic push_adrs(input int n);
    for (int i = 0; i < n; i++) adr_q.push_back(BASE + (i % WORDS));
  endtask

  task automatic run_until(input int n, input bit toggle);
    int budget;
    budget = 3 * (n - ticks) + 200;
    while (ticks < n && budget > 0) begin
      @(negedge clk);
      pix_en = toggle ? ~pix_en : 1'b1;
      budget--;
    end
    if (ticks < n) begin
      checks++;
      errors++;
      $display("FAIL run_until: ticks %0d, required %0d", ticks, n);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ticks <= 0;
    else if (pix_en) ticks <= ticks + 1;
  end

  // Video monitor: raster timing from the tick count, pixels from the queue.
  int       p, h, v;
  bit       new_s, exp_hs, exp_vs, exp_act;
  pix_exp_t got;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_outputs", int'({pixel, hsync, vsync, active, underrun, fb_req}), 6'b011000);
      check("rst_fb_adr", int'(fb_adr), BASE);
      last_ticks = 0;
    end else begin
      new_s = (ticks != last_ticks);
      last_ticks = ticks;
      if (ticks == 0) begin
        exp_hs = 1'b1; exp_vs = 1'b1; exp_act = 1'b0; h = -1; v = -1;
      end else begin
        p = ticks - 1;
        h = p % H_TOTAL;
        v = (p / H_TOTAL) % V_TOTAL;
        exp_hs  = !(h >= H_ACTIVE + H_FRONT && h < H_ACTIVE + H_FRONT + H_SYNC);
        exp_vs  = !(v >= V_ACTIVE + V_FRONT && v < V_ACTIVE + V_FRONT + V_SYNC);
        exp_act = (h < H_ACTIVE) && (v < V_ACTIVE);
      end
      check($sformatf("sync h%0d v%0d", h, v), int'({hsync, vsync, active}),
            int'({exp_hs, exp_vs, exp_act}));
      if (new_s && exp_act) begin
        if (pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_queue: unexpected pixel %0d at h%0d v%0d, expected none", pixel, h, v);
        end else begin
          got = pix_q.pop_front();
          check($sformatf("pixel h%0d v%0d", h, v), int'(pixel), int'(got.pix));
          check($sformatf("underrun h%0d v%0d", h, v), int'(underrun), int'(got.und));
        end
      end else begin
        check("underrun_idle", int'(underrun), 0);
        if (!exp_act) check("blank_pixel", int'(pixel), 0);
      end
    end
  end

  // Memory responder: acks one cycle after fb_req by default, checks each accepted address.
  int          age = 0;
  int          tgt;
  bit          held_valid = 0;
  logic [14:0] held_adr;
  always @(negedge clk) begin
    fb_ack = 1'b0;
    if (!rst_n || !fb_req) begin
      age = 0;
      held_valid = 0;
    end else begin
      if (held_valid) check("adr_stable", int'(fb_adr), int'(held_adr));
      held_valid = 1;
      held_adr = fb_adr;
      tgt = (late_mode && int'(fb_adr) == BASE + 5) ? 21 : 1;
      if (!(hold7 && int'(fb_adr) == BASE + 7) && age >= tgt) begin
        fb_ack = 1'b1;
        fb_data = (int'(fb_adr) >= BASE && int'(fb_adr) < BASE + WORDS) ?
                  mem[int'(fb_adr) - BASE] : 16'h0000;
        if (adr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_adr: got %0d, expected no request", fb_adr);
        end else begin
          check("fetch_adr", int'(fb_adr), adr_q.pop_front());
        end
        held_valid = 0;
      end else begin
        age++;
      end
    end
  end

  initial begin
    bit found;
    mem[0] = 16'h0001; mem[1] = 16'h8000; mem[2] = 16'hA5C3; mem[3] = 16'h0F0F;
    mem[4] = 16'h1234; mem[5] = 16'hC001; mem[6] = 16'h5A5A; mem[7] = 16'hFFFF;
    rst_n   = 1'b0;
    pix_en  = 1'b1;
    fb_ack  = 1'b0;
    fb_data = 16'h0000;

    // Frame 0 starts with an empty prefetch: slot 0 underruns, the rest lag one word.
    push_frame(32'h6543210F);
    push_frame(32'h76543210);   // frame 1: aligned, pix_en high
    push_frame(32'h76543210);   // frame 2: pix_en toggling
    push_frame(32'h65F43210);   // frame 3: word 5 acked late
    push_frame(32'hF6543210);   // frame 4: word 7 held across the flush
    push_frame(32'h76543210);   // frame 5: discarded data must not appear
    push_adrs(6 * WORDS);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_until(FRAME + 200, 1'b0);
    run_until(2 * FRAME + 200, 1'b1);
    late_mode = 1'b1;
    run_until(3 * FRAME + 200, 1'b0);
    late_mode = 1'b0;
    hold7 = 1'b1;
    run_until(4 * FRAME + 196, 1'b0);
    hold7 = 1'b0;
    run_until(5 * FRAME + 100, 1'b0);

    // Reset in the middle of an outstanding request.
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      found = fb_req;
    end
    check("req_before_reset", int'(found), 1);
    rst_n = 1'b0;
    #1;
    check("async_req_drop", int'(fb_req), 0);
    check("async_rst_outputs", int'({pixel, hsync, vsync, active, underrun}), 5'b01100);
    check("async_rst_adr", int'(fb_adr), BASE);
    pix_q.delete();
    adr_q.delete();
    push_frame(32'h6543210F);
    push_adrs(WORDS + 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_until(FRAME - 10, 1'b0);

    check("pixel_queue_drained", pix_q.size(), 0);
    check("adr_queue_drained", adr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/screen_scanner.md
# screen_scanner

Display-side reader for the memory-mapped screen region. Fetches framebuffer words (512×256 monochrome, 32 words per line, 8192 words) from data memory over a request/acknowledge read port. Serializes each word into 16 pixels and generates raster timing (hsync, vsync, active). It sits between the memory read arbiter and the video output pins.

## Interface
- `H_ACTIVE`, default 512: visible pixels per line; must be a multiple of 16.
- `H_FRONT` / `H_SYNC` / `H_BACK`, default 16 / 64 / 48: horizontal blanking lengths, in pixels.
- `V_ACTIVE`, default 256: visible lines.
- `V_FRONT` / `V_SYNC` / `V_BACK`, default 10 / 2 / 33: vertical blanking lengths, in lines.
- `BASE_ADR`, default 16384: word address of pixel (0,0).
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pix_en` in 1: pixel-rate enable; one pixel advances per cycle in which it is high.
- `fb_req` out 1: read request.
- `fb_adr` out 15: read word address.
- `fb_ack` in 1: request accepted; `fb_data` is valid in the same cycle.
- `fb_data` in 16: read data.
- `pixel` out 1: 1 = black, 0 = white.
- `hsync` out 1: active-low horizontal sync.
- `vsync` out 1: active-low vertical sync.
- `active` out 1: high during the visible area.
- `underrun` out 1: one-cycle pulse when a word was not available in time.

## Operation
- **Counters.** `h_cnt` counts 0..H_TOTAL-1 and `v_cnt` counts 0..V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK and V_TOTAL likewise.
  - Both advance only on `pix_en`.
  - `h_cnt` wraps to 0 and increments `v_cnt`. `v_cnt` wraps to 0 after V_TOTAL-1.
- **Sync and active windows.**
  - Visible area: `h_cnt` < H_ACTIVE and `v_cnt` < V_ACTIVE.
  - `hsync` is low for `h_cnt` in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - `vsync` is low for `v_cnt` in the corresponding vertical window.
- **Buffering.**
  - `shift` holds the current word. `next` holds the prefetched word and has a `next_full` flag.
  - At every visible pixel with `h_cnt[3:0]`=0:
    - if `next_full`, `next` loads into `shift` and `next_full` clears;
    - otherwise `shift` loads 0 and `underrun` pulses.
  - `pixel` = `shift` bit (`h_cnt[3:0]`); bit 0 is the leftmost pixel. `pixel` = 0 outside the visible area.
- **Fetch FSM** (states IDLE, REQ):
  - IDLE → REQ when `next_full`=0 and `fetch_idx` < H_ACTIVE/16·V_ACTIVE. On entry, `fb_adr` = BASE_ADR + `fetch_idx` and `fb_req`=1.
  - REQ holds `fb_req` and `fb_adr` stable until `fb_ack`.
  - On `fb_ack`: `next` ← `fb_data`, `next_full`=1, `fetch_idx`++, `fb_req`=0, → IDLE.
  - `fb_ack` while in IDLE is ignored.
- **Frame flush.** At the `pix_en` with `h_cnt`=0 and `v_cnt`=V_ACTIVE:
  - `next_full` clears and `fetch_idx` resets to 0.
  - If the FSM is in REQ, that request still completes, but its data is discarded: `next_full` stays 0 and `fetch_idx` is not incremented.
  - Word 0 of the next frame is then prefetched during vertical blanking.
- **Reset.** Asynchronous assertion of `rst_n` takes effect immediately, including mid-request; `fb_req` drops at once. Reset values:
  - counters 0, `shift` 0, `next_full` 0, `fetch_idx` 0, FSM IDLE;
  - `fb_req` 0, `fb_adr` BASE_ADR;
  - `pixel` 0, `hsync` 1, `vsync` 1, `active` 0, `underrun` 0.

## Timing
- `pixel`, `hsync`, `vsync` and `active` are registered. Each reflects the counter values of the `pix_en` cycle and appears one `clk` later; it holds until the next `pix_en`.
- The `underrun` pulse is also registered. It is high for exactly one `clk`, aligned with the first pixel of the affected word.
- A new request is issued the cycle after `next_full` clears. The first request after reset is issued in the first cycle after `rst_n` deasserts.
- Fetch slack is 16 `pix_en` periods per word. With `pix_en` tied high, an `fb_ack` latency of up to 14 cycles never underruns.
- At the frame flush cycle, flush wins over a simultaneous `fb_ack`: the data is dropped.
- `fetch_idx` never exceeds 8192. No fetch is issued beyond BASE_ADR+8191.

## Test plan
- **Reset values.** Hold reset, then release with `pix_en`=1 and `fb_ack` returned the cycle after `fb_req`.
  - Outputs hold their reset values during reset.
  - First `fb_adr` is 16384.
  - `hsync` falls at `h_cnt`=528 and rises at 592; line period is 640 `pix_en`.
- **Pixel order and alignment.** Memory word 16384 = 16'h0001, word 16385 = 16'h8000.
  - Line 0: pixel 0 = 1, pixels 1–30 = 0, pixel 31 = 1.
  - No `underrun` pulse.
- **Frame sequencing.** Full frame with `pix_en`=1.
  - Exactly 8192 acks, with addresses 16384..24575 in order.
  - `vsync` low for `v_cnt` 266–267.
  - Second frame starts again at 16384.
- **Late acknowledge.** Delay `fb_ack` by 20 cycles on word 5.
  - `underrun` pulses at pixel 80; pixels 80–95 = 0.
  - Word 5 data is then displayed at word slot 6.
  - `fb_adr` never changes while `fb_req` is high.
- **Flush during request.** Hold `fb_ack` low across `v_cnt`=256, `h_cnt`=0, then ack with 16'hFFFF.
  - The data is discarded.
  - The next request address is 16384.
- **Mid-request reset.** Assert `rst_n`=0 while `fb_req`=1.
  - `fb_req` drops in the same cycle, asynchronously.
  - After release, all state equals the reset values and fetching restarts at 16384.
